cell_scan_monitor: RTL and testbench

CELL_SCAN_MONITOR -- requirements
Module: cell_scan_monitor

---
 rtl/cell_scan_monitor_pkg.sv | 22 ++
 rtl/cell_scan_monitor_hbridge_pair_decode.sv | 16 +
 rtl/cell_scan_monitor.sv | 246 ++++++++++++++++++++++++
 tb/tb_cell_scan_monitor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_scan_monitor_pkg.sv
// Shared definitions for the cell scan monitor: H-bridge pair codes,
// scan FSM encoding and a saturating increment helper.
package cell_scan_monitor_pkg;

   // Two-bit H-bridge pair codes as driven by the matrix driver
   localparam logic [1:0] HB_HIGH    = 2'b11;
   localparam logic [1:0] HB_LOW     = 2'b00;
   localparam logic [1:0] HB_OFF     = 2'b10;
   localparam logic [1:0] HB_ILLEGAL = 2'b01;

   // Scan FSM: wait for a frame boundary, then collect cells frame by frame
   typedef enum logic {
      ST_SYNC    = 1'b0,
      ST_COLLECT = 1'b1
   } scan_state_e;

   // 16-bit increment that sticks at all-ones
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/cell_scan_monitor_hbridge_pair_decode.sv
// Decodes one H-bridge pair code into active / level / illegal flags.
module hbridge_pair_decode
   import cell_scan_monitor_pkg::*;
(
   input  logic [1:0] code_i,
   output logic       active_o,
   output logic       level_o,
   output logic       illegal_o
);

   // A pair drives the matrix only when it is firmly high or low
   assign active_o  = (code_i == HB_HIGH) || (code_i == HB_LOW);
   assign level_o   = (code_i == HB_HIGH);
   assign illegal_o = (code_i == HB_ILLEGAL);

endmodule

// File: rtl/cell_scan_monitor.sv
// Cell scan monitor: watches row/column H-bridge activity of a scanned
// matrix, reconstructs which cells were driven to which value in each
// frame and publishes the result at every frame-end marker.
module cell_scan_monitor
   import cell_scan_monitor_pkg::*;
#(
   parameter int NUM_ROWS = 5,
   parameter int NUM_COLS = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [2*NUM_ROWS-1:0]        rows_hbrige,
   input  logic [2*NUM_COLS-1:0]        cols_hbrige,
   input  logic                         update_done,
   input  logic                         cell_invert,
   input  logic [15:0]                  min_pulse,
   input  logic [31:0]                  frame_timeout,
   input  logic                         err_clear,
   output logic [NUM_ROWS*NUM_COLS-1:0] frame_state,
   output logic [NUM_ROWS*NUM_COLS-1:0] frame_mask,
   output logic                         frame_valid,
   output logic [15:0]                  frame_count,
   output logic                         err_overlap,
   output logic                         err_illegal,
   output logic                         err_polarity,
   output logic                         err_timeout
);

   localparam int NUM_CELLS = NUM_ROWS * NUM_COLS;
   localparam int IDX_W     = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

   // ---------------- pair decode ----------------
   logic [NUM_ROWS-1:0] row_act, row_lev, row_ill;
   logic [NUM_COLS-1:0] col_act, col_lev, col_ill;

   generate
      for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
         hbridge_pair_decode u_row_dec (
            .code_i    (rows_hbrige[2*gi +: 2]),
            .active_o  (row_act[gi]),
            .level_o   (row_lev[gi]),
            .illegal_o (row_ill[gi])
         );
      end
      for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
         hbridge_pair_decode u_col_dec (
            .code_i    (cols_hbrige[2*gi +: 2]),
            .active_o  (col_act[gi]),
            .level_o   (col_lev[gi]),
            .illegal_o (col_ill[gi])
         );
      end
   endgenerate

   // ---------------- state ----------------
   scan_state_e            state_q, state_d;
   logic                   ud_q;
   logic [15:0]            dwell_q, dwell_d;
   logic [IDX_W-1:0]       slot_q, slot_d;
   logic [31:0]            frame_cyc_q, frame_cyc_d;
   logic [NUM_CELLS-1:0]   acc_state_q, acc_state_d;
   logic [NUM_CELLS-1:0]   acc_mask_q, acc_mask_d;
   logic [NUM_CELLS-1:0]   frame_state_q, frame_state_d;
   logic [NUM_CELLS-1:0]   frame_mask_q, frame_mask_d;
   logic                   frame_valid_q;
   logic [15:0]            frame_count_q, frame_count_d;
   logic                   err_overlap_q, err_illegal_q, err_polarity_q, err_timeout_q;

   // ---------------- slot classification ----------------
   logic             any_illegal;
   int               row_cnt, col_cnt, r_sel, c_sel;
   logic             row_lvl, col_lvl;
   logic             slot_valid, polarity_bad, overlap;
   logic [IDX_W-1:0] slot_idx;
   logic             cell_bit;

   // Count active rows/columns, remember the selected ones and their levels
   always_comb begin
      any_illegal = 1'b0;
      row_cnt     = 0;
      col_cnt     = 0;
      r_sel       = 0;
      c_sel       = 0;
      row_lvl     = 1'b0;
      col_lvl     = 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) begin
         if (row_ill[i]) any_illegal = 1'b1;
         if (row_act[i]) begin
            row_cnt = row_cnt + 1;
            r_sel   = i;
            row_lvl = row_lev[i];
         end
      end
      for (int i = 0; i < NUM_COLS; i++) begin
         if (col_ill[i]) any_illegal = 1'b1;
         if (col_act[i]) begin
            col_cnt = col_cnt + 1;
            c_sel   = i;
            col_lvl = col_lev[i];
         end
      end
   end

   assign overlap      = (row_cnt > 1) || (col_cnt > 1);
   assign slot_valid   = !any_illegal && (row_cnt == 1) && (col_cnt == 1);
   assign polarity_bad = slot_valid && (row_lvl == col_lvl);
   assign slot_idx     = IDX_W'(c_sel * NUM_ROWS + r_sel);
   assign cell_bit     = row_lvl ^ cell_invert;

   // ---------------- dwell / capture ----------------
   logic                 in_collect, ud_rise, continuing, capture;
   logic [15:0]          thresh;
   logic [NUM_CELLS-1:0] acc_state_m, acc_mask_m;

   assign in_collect = (state_q == ST_COLLECT);
   assign ud_rise    = update_done && !ud_q;
   assign thresh     = (min_pulse == 16'd0) ? 16'd1 : min_pulse;

   // Dwell counter tracks how long the current slot has been held; a
   // capture fires once when it reaches the threshold (the saturated
   // case is excluded so a long dwell cannot capture repeatedly)
   always_comb begin
      continuing  = slot_valid && (dwell_q != 16'd0) && (slot_idx == slot_q);
      dwell_d     = 16'd0;
      slot_d      = slot_q;
      capture     = 1'b0;
      acc_state_m = acc_state_q;
      acc_mask_m  = acc_mask_q;
      if (in_collect && slot_valid) begin
         dwell_d = continuing ? sat_inc16(dwell_q) : 16'd1;
         slot_d  = slot_idx;
         capture = !polarity_bad && (dwell_d == thresh) &&
                   !(continuing && (dwell_q == 16'hFFFF));
      end
      if (capture) begin
         acc_state_m[slot_idx] = cell_bit;
         acc_mask_m[slot_idx]  = 1'b1;
      end
   end

   // ---------------- FSM next state, publish and timeout ----------------
   logic        publish, timeout_evt;
   logic [31:0] cyc_inc;

   assign cyc_inc = frame_cyc_q + 32'd1;

   // Next-state logic; captures made this cycle are already merged into acc
   always_comb begin
      state_d     = state_q;
      acc_state_d = acc_state_m;
      acc_mask_d  = acc_mask_m;
      frame_cyc_d = frame_cyc_q;
      publish     = 1'b0;
      timeout_evt = 1'b0;
      case (state_q)
         ST_SYNC: begin
            acc_state_d = '0;
            acc_mask_d  = '0;
            frame_cyc_d = 32'd0;
            if (ud_rise) state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (ud_rise) begin
               publish     = 1'b1;
               acc_state_d = '0;
               acc_mask_d  = '0;
               frame_cyc_d = 32'd0;
            end else if ((frame_timeout != 32'd0) && (cyc_inc >= frame_timeout)) begin
               timeout_evt = 1'b1;
               acc_state_d = '0;
               acc_mask_d  = '0;
               frame_cyc_d = 32'd0;
            end else begin
               frame_cyc_d = cyc_inc;
            end
         end
         default: state_d = ST_SYNC;
      endcase
   end

   // Published frame: cells not driven this frame keep their previous value
   always_comb begin
      frame_state_d = frame_state_q;
      frame_mask_d  = frame_mask_q;
      frame_count_d = frame_count_q;
      if (publish) begin
         frame_state_d = (acc_mask_m & acc_state_m) | (~acc_mask_m & frame_state_q);
         frame_mask_d  = acc_mask_m;
         frame_count_d = frame_count_q + 16'd1;
      end
   end

   // State, accumulator and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_SYNC;
         ud_q          <= 1'b0;
         dwell_q       <= '0;
         slot_q        <= '0;
         frame_cyc_q   <= '0;
         acc_state_q   <= '0;
         acc_mask_q    <= '0;
         frame_state_q <= '0;
         frame_mask_q  <= '0;
         frame_valid_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ud_q          <= update_done;
         dwell_q       <= dwell_d;
         slot_q        <= slot_d;
         frame_cyc_q   <= frame_cyc_d;
         acc_state_q   <= acc_state_d;
         acc_mask_q    <= acc_mask_d;
         frame_state_q <= frame_state_d;
         frame_mask_q  <= frame_mask_d;
         frame_valid_q <= publish;
         frame_count_q <= frame_count_d;
      end
   end

   // Sticky error flags; a fresh event outranks a simultaneous clear
   always_ff @(posedge clock) begin
      if (reset) begin
         err_overlap_q  <= 1'b0;
         err_illegal_q  <= 1'b0;
         err_polarity_q <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         err_overlap_q  <= (in_collect && overlap)      || (err_overlap_q  && !err_clear);
         err_illegal_q  <= (in_collect && any_illegal)  || (err_illegal_q  && !err_clear);
         err_polarity_q <= (in_collect && polarity_bad) || (err_polarity_q && !err_clear);
         err_timeout_q  <= timeout_evt                  || (err_timeout_q  && !err_clear);
      end
   end

   assign frame_state  = frame_state_q;
   assign frame_mask   = frame_mask_q;
   assign frame_valid  = frame_valid_q;
   assign frame_count  = frame_count_q;
   assign err_overlap  = err_overlap_q;
   assign err_illegal  = err_illegal_q;
   assign err_polarity = err_polarity_q;
   assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_cell_scan_monitor.sv
// Scoreboard bench for cell_scan_monitor: expected frames are queued when
// update_done is driven and compared when frame_valid appears.
module tb_cell_scan_monitor;

   localparam int NR = 5;
   localparam int NC = 2;

   logic            clock = 1'b0;
   logic            reset;
   logic [2*NR-1:0] rows_hbrige;
   logic [2*NC-1:0] cols_hbrige;
   logic            update_done;
   logic            cell_invert;
   logic [15:0]     min_pulse;
   logic [31:0]     frame_timeout;
   logic            err_clear;
   logic [9:0]      frame_state;
   logic [9:0]      frame_mask;
   logic            frame_valid;
   logic [15:0]     frame_count;
   logic            err_overlap, err_illegal, err_polarity, err_timeout;

   cell_scan_monitor #(.NUM_ROWS(NR), .NUM_COLS(NC)) dut (
      .clock         (clock),
      .reset         (reset),
      .rows_hbrige   (rows_hbrige),
      .cols_hbrige   (cols_hbrige),
      .update_done   (update_done),
      .cell_invert   (cell_invert),
      .min_pulse     (min_pulse),
      .frame_timeout (frame_timeout),
      .err_clear     (err_clear),
      .frame_state   (frame_state),
      .frame_mask    (frame_mask),
      .frame_valid   (frame_valid),
      .frame_count   (frame_count),
      .err_overlap   (err_overlap),
      .err_illegal   (err_illegal),
      .err_polarity  (err_polarity),
      .err_timeout   (err_timeout)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [9:0]  st;
      logic [9:0]  mk;
      logic [15:0] cnt;
   } frame_t;

   frame_t      exp_q[$];
   int          total = 0;
   int          bad   = 0;
   int          fv_seen = 0;
   logic [15:0] exp_cnt = 16'd0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   // Monitor: every frame_valid pulse must match the oldest queued frame
   always @(negedge clock) begin
      if (frame_valid) begin
         fv_seen++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_frame_valid", 32'd1, 32'd0);
         end else begin
            frame_t e;
            e = exp_q.pop_front();
            check_val("frame_state", 32'(frame_state), 32'(e.st));
            check_val("frame_mask",  32'(frame_mask),  32'(e.mk));
            check_val("frame_count", 32'(frame_count), 32'(e.cnt));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic idle_bridges();
      rows_hbrige = {NR{2'b10}};
      cols_hbrige = {NC{2'b10}};
   endtask

   task automatic drive_slot(input int r, input int c, input logic [1:0] rc, input logic [1:0] cc);
      idle_bridges();
      rows_hbrige[2*r +: 2] = rc;
      cols_hbrige[2*c +: 2] = cc;
   endtask

   task automatic push_frame(input logic [9:0] st, input logic [9:0] mk);
      frame_t e;
      exp_cnt = exp_cnt + 16'd1;
      e.st = st; e.mk = mk; e.cnt = exp_cnt;
      exp_q.push_back(e);
   endtask

   // Frame-end pulse; expect a publish only when exp_pub is set
   task automatic frame_end(input logic exp_pub, input logic [9:0] st, input logic [9:0] mk);
      int fv_before;
      fv_before = fv_seen;
      if (exp_pub) push_frame(st, mk);
      update_done = 1'b1;
      @(negedge clock);
      update_done = 1'b0;
      cycles(3);
      check_val("frame_drain", 32'(exp_q.size()), 32'd0);
      check_val("frame_valid_pulses", 32'(fv_seen - fv_before), exp_pub ? 32'd1 : 32'd0);
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      @(negedge clock);
      err_clear = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_state"}, 32'(frame_state), 32'd0);
      check_val({tag, "_mask"},  32'(frame_mask),  32'd0);
      check_val({tag, "_valid"}, 32'(frame_valid), 32'd0);
      check_val({tag, "_count"}, 32'(frame_count), 32'd0);
      check_val({tag, "_errs"},  {28'd0, err_overlap, err_illegal, err_polarity, err_timeout}, 32'd0);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      exp_cnt = 16'd0;
   endtask

   initial begin
      reset = 1'b1; update_done = 1'b0; cell_invert = 1'b0; min_pulse = 16'd3;
      frame_timeout = 32'd0; err_clear = 1'b0;
      idle_bridges();
      cycles(3);
      check_all_zero("reset");
      reset = 1'b0;
      cycles(1);

      // First edge after reset only synchronises
      frame_end(1'b0, 10'h0, 10'h0);

      // Slot row0 high / col0 low held 4 cycles with min_pulse=3 -> captured
      drive_slot(0, 0, 2'b11, 2'b00);
      cycles(4);
      idle_bridges();
      frame_end(1'b1, 10'h001, 10'h001);

      // Slot held only 2 cycles -> nothing captured, state kept
      drive_slot(2, 0, 2'b11, 2'b00);
      cycles(2);
      idle_bridges();
      frame_end(1'b1, 10'h001, 10'h000);

      // Two rows active -> overlap, no capture, then clear
      idle_bridges();
      rows_hbrige[3:2] = 2'b11;
      rows_hbrige[5:4] = 2'b11;
      cols_hbrige[3:2] = 2'b00;
      cycles(4);
      idle_bridges();
      check_val("err_overlap_set", 32'(err_overlap), 32'd1);
      frame_end(1'b1, 10'h001, 10'h000);
      pulse_clear();
      check_val("err_overlap_clr", 32'(err_overlap), 32'd0);

      // Same levels on row and column -> polarity error, no capture
      drive_slot(4, 1, 2'b11, 2'b11);
      cycles(4);
      idle_bridges();
      check_val("err_polarity_set", 32'(err_polarity), 32'd1);
      pulse_clear();
      check_val("err_polarity_clr", 32'(err_polarity), 32'd0);

      // Illegal code -> err_illegal; clear while event persists keeps it set
      idle_bridges();
      cols_hbrige[1:0] = 2'b01;
      cycles(2);
      check_val("err_illegal_set", 32'(err_illegal), 32'd1);
      pulse_clear();
      check_val("err_illegal_clear_vs_event", 32'(err_illegal), 32'd1);
      idle_bridges();
      cycles(1);
      pulse_clear();
      check_val("err_illegal_clr", 32'(err_illegal), 32'd0);
      frame_end(1'b1, 10'h001, 10'h000);

      // Inverted polarity: row3 low, col1 high -> cell 8 reads 1
      cell_invert = 1'b1;
      drive_slot(3, 1, 2'b00, 2'b11);
      cycles(4);
      idle_bridges();
      frame_end(1'b1, 10'h101, 10'h100);

      // min_pulse=0 behaves as 1: single-cycle slot captured (bit = 1^1 = 0)
      min_pulse = 16'd0;
      drive_slot(2, 0, 2'b11, 2'b00);
      cycles(1);
      idle_bridges();
      frame_end(1'b1, 10'h101, 10'h004);
      min_pulse = 16'd3;
      cell_invert = 1'b0;

      // Capture in the same cycle as the frame end is part of that frame
      drive_slot(1, 0, 2'b11, 2'b00);
      cycles(2);
      push_frame(10'h103, 10'h002);
      update_done = 1'b1;
      @(negedge clock);
      update_done = 1'b0;
      idle_bridges();
      cycles(3);
      check_val("same_cycle_drain", 32'(exp_q.size()), 32'd0);

      // Timeout: captured data is discarded and no frame is published
      frame_timeout = 32'd100;
      begin
         int fv_before;
         fv_before = fv_seen;
         drive_slot(0, 0, 2'b00, 2'b11);
         cycles(4);
         idle_bridges();
         cycles(106);
         check_val("err_timeout_set", 32'(err_timeout), 32'd1);
         check_val("timeout_no_frame", 32'(fv_seen - fv_before), 32'd0);
      end
      frame_timeout = 32'd0;
      pulse_clear();
      check_val("err_timeout_clr", 32'(err_timeout), 32'd0);
      frame_end(1'b1, 10'h103, 10'h000);

      // Reset mid-collection wipes everything; next edge only resyncs
      drive_slot(0, 0, 2'b11, 2'b00);
      cycles(4);
      apply_reset();
      idle_bridges();
      check_all_zero("midreset");
      frame_end(1'b0, 10'h0, 10'h0);
      frame_end(1'b1, 10'h000, 10'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
